learn_costs_q: RTL and testbench

//  Parametrised successor to the single-shot cost learner. Accepts feedback packets
//  (source ID, battery status, value, cluster ID) through a valid/ready FIFO and, per packet,

---
 rtl/learn_costs_q_if.sv | 26 ++
 rtl/learn_costs_q.sv | 185 ++++++++++++++++++
 tb/tb_learn_costs_q.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/learn_costs_q_if.sv
// Feedback-packet handshake plus shared memory bus for the Q-value cost learner.
interface learn_costs_q_if #(parameter int WORD_WIDTH = 16);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] fsourceID;
    logic [WORD_WIDTH-1:0] fbatteryStat;
    logic [WORD_WIDTH-1:0] fValue;
    logic [WORD_WIDTH-1:0] fclusterID;
    logic [WORD_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] data_in;
    logic [WORD_WIDTH-1:0] data_out;
    logic                  reinit;
    logic                  done;
    logic                  tbl_full_err;
    logic                  busy;

    modport slave (
        input  in_valid, fsourceID, fbatteryStat, fValue, fclusterID, data_out,
        output in_ready, address, wr_en, data_in, reinit, done, tbl_full_err, busy
    );
    modport master (
        output in_valid, fsourceID, fbatteryStat, fValue, fclusterID, data_out,
        input  in_ready, address, wr_en, data_in, reinit, done, tbl_full_err, busy
    );
endinterface

// File: rtl/learn_costs_q.sv
// Queued feedback packets drive a read-modify-write of the neighbour Q table in shared memory.
// Learning step is Q += (target - Q) >>> ALPHA_SHIFT; unknown sources are appended if room remains.
module learn_costs_q #(
    parameter int WORD_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int NBR_MAX     = 8,
    parameter int TABLE_BASE  = 'h0100,
    parameter int ADDR_STEP   = 2,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic           clock,
    input  logic           nreset,
    learn_costs_q_if.slave bus
);
    localparam int WW = WORD_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [WW-1:0] src;
        logic [WW-1:0] bat;
        logic [WW-1:0] val;
        logic [WW-1:0] cl;
    } pkt_t;

    typedef enum logic [3:0] {
        IDLE, RD_CNT, LD_CNT, RD_ID, CMP, NEW, FULL, RD_Q,
        CALC, WR_ID, WR_Q, RD_CL, CHK_CL, WR_CL, WR_CNT, DONE
    } state_t;

    state_t state, state_nxt;

    pkt_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fcount;
    logic          full, empty, push, pop;

    assign full         = (fcount == (PW+1)'(FIFO_DEPTH));
    assign empty        = (fcount == '0);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = (state == IDLE) && !empty;
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge clock)
        if (push) fifo_mem[wr_ptr] <= pkt_t'{bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID};

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fcount <= fcount + 1'b1;
                2'b01:   fcount <= fcount - 1'b1;
                default: ;
            endcase
        end
    end

    pkt_t          pkt;
    logic [WW-1:0] cnt, k, q_new;
    logic          is_new;

    logic [WW:0]        sum;
    logic [WW-1:0]      target, q_calc;
    logic signed [WW:0] diff, shifted;
    logic [WW-1:0]      ent_addr, q_addr, cl_addr;

    assign sum     = {1'b0, pkt.val} + {1'b0, pkt.bat};
    assign target  = sum[WW] ? '1 : sum[WW-1:0];
    // One extra bit keeps the difference signed; the arithmetic shift floors toward -inf.
    assign diff    = $signed({1'b0, target}) - $signed({1'b0, bus.data_out});
    assign shifted = diff >>> ALPHA_SHIFT;
    assign q_calc  = WW'(shifted + $signed({1'b0, bus.data_out}));

    assign ent_addr = WW'(TABLE_BASE) + WW'(ADDR_STEP) * (WW'(1) + WW'(3) * k);
    assign q_addr   = ent_addr + WW'(ADDR_STEP);
    assign cl_addr  = ent_addr + WW'(2 * ADDR_STEP);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pkt    <= '0;
            cnt    <= '0;
            k      <= '0;
            q_new  <= '0;
            is_new <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (!empty) begin
                             pkt    <= fifo_mem[rd_ptr];
                             is_new <= 1'b0;
                         end
                LD_CNT:  begin
                             cnt <= bus.data_out;
                             k   <= '0;
                         end
                // Leaving CMP on a miss with k+1==cnt makes k the append slot.
                CMP:     if (bus.data_out != pkt.src) k <= k + 1'b1;
                NEW:     begin
                             is_new <= 1'b1;
                             q_new  <= target;
                         end
                CALC:    q_new <= q_calc;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset)
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;

    always_comb begin
        state_nxt        = state;
        bus.address      = '0;
        bus.wr_en        = 1'b0;
        bus.data_in      = '0;
        bus.reinit       = 1'b0;
        bus.done         = 1'b0;
        bus.tbl_full_err = 1'b0;
        case (state)
            IDLE:   if (!empty) state_nxt = RD_CNT;
            RD_CNT: begin
                        bus.address = WW'(TABLE_BASE);
                        state_nxt   = LD_CNT;
                    end
            LD_CNT: state_nxt = (bus.data_out == '0) ? NEW : RD_ID;
            RD_ID:  begin
                        bus.address = ent_addr;
                        state_nxt   = CMP;
                    end
            CMP:    if (bus.data_out == pkt.src) state_nxt = RD_Q;
                    else if (k + 1'b1 == cnt)    state_nxt = NEW;
                    else                         state_nxt = RD_ID;
            NEW:    state_nxt = (cnt < WW'(NBR_MAX)) ? WR_ID : FULL;
            FULL:   begin
                        bus.tbl_full_err = 1'b1;
                        state_nxt        = DONE;
                    end
            RD_Q:   begin
                        bus.address = q_addr;
                        state_nxt   = CALC;
                    end
            CALC:   state_nxt = WR_Q;
            WR_ID:  begin
                        bus.address = ent_addr;
                        bus.data_in = pkt.src;
                        bus.wr_en   = 1'b1;
                        state_nxt   = WR_Q;
                    end
            WR_Q:   begin
                        bus.address = q_addr;
                        bus.data_in = q_new;
                        bus.wr_en   = 1'b1;
                        state_nxt   = is_new ? WR_CL : RD_CL;
                    end
            RD_CL:  begin
                        bus.address = cl_addr;
                        state_nxt   = CHK_CL;
                    end
            CHK_CL: state_nxt = (bus.data_out != pkt.cl) ? WR_CL : DONE;
            WR_CL:  begin
                        bus.address = cl_addr;
                        bus.data_in = pkt.cl;
                        bus.wr_en   = 1'b1;
                        bus.reinit  = !is_new;
                        state_nxt   = is_new ? WR_CNT : DONE;
                    end
            WR_CNT: begin
                        bus.address = WW'(TABLE_BASE);
                        bus.data_in = cnt + 1'b1;
                        bus.wr_en   = 1'b1;
                        state_nxt   = DONE;
                    end
            DONE:   begin
                        bus.done  = 1'b1;
                        state_nxt = IDLE;
                    end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_learn_costs_q.sv
// Scoreboarded random/directed bench for learn_costs_q against a table-level reference model.
module tb_learn_costs_q;
    localparam int WW   = 16;
    localparam int A    = 2;
    localparam int NMAX = 8;
    localparam int BASE = 'h100;

    logic clock = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    learn_costs_q_if #(.WORD_WIDTH(WW)) bus();

    learn_costs_q #(.WORD_WIDTH(WW), .FIFO_DEPTH(4), .NBR_MAX(NMAX), .TABLE_BASE(BASE),
                    .ADDR_STEP(2), .ALPHA_SHIFT(A)) dut (
        .clock(clock), .nreset(nreset), .bus(bus));

    // Word-addressed memory model with registered read data
    logic [15:0] mem [0:511];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    always @(posedge clock) begin
        if (pre_we)          mem[pre_addr] <= pre_data;
        else if (bus.wr_en)  mem[bus.address[8:0]] <= bus.data_in;
        bus.data_out <= mem[bus.address[8:0]];
    end

    typedef struct {int addr; int data;} wr_t;
    typedef struct {int r; int f;} pk_t;
    wr_t exp_wr[$];
    pk_t exp_pk[$];
    int  m_id[$], m_q[$], m_cl[$];
    int  checks = 0, errors = 0, n_exp = 0, n_done = 0, r_cnt = 0, f_cnt = 0;
    bit  mon_en = 1'b1;
    wr_t mon_e;
    pk_t mon_p;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met", name);
    endtask

    function automatic int ent(int k);
        return BASE + 2 * (1 + 3 * k);
    endfunction

    // Reference: search table, learn or append, and list the writes that must appear
    task automatic apply(int src, int bat, int val, int cl);
        int tgt, idx, d, st, qn, k;
        pk_t p;
        tgt = bat + val;
        if (tgt > 65535) tgt = 65535;
        idx = -1;
        for (int i = 0; i < m_id.size(); i++) if (idx < 0 && m_id[i] == src) idx = i;
        p.r = 0;
        p.f = 0;
        if (idx >= 0) begin
            d  = tgt - m_q[idx];
            st = d / (1 << A);
            if (d < 0 && (d % (1 << A)) != 0) st--;
            qn = m_q[idx] + st;
            m_q[idx] = qn;
            exp_wr.push_back(wr_t'{ent(idx) + 2, qn});
            if (m_cl[idx] != cl) begin
                m_cl[idx] = cl;
                exp_wr.push_back(wr_t'{ent(idx) + 4, cl});
                p.r = 1;
            end
        end else if (m_id.size() < NMAX) begin
            k = m_id.size();
            m_id.push_back(src);
            m_q.push_back(tgt);
            m_cl.push_back(cl);
            exp_wr.push_back(wr_t'{ent(k), src});
            exp_wr.push_back(wr_t'{ent(k) + 2, tgt});
            exp_wr.push_back(wr_t'{ent(k) + 4, cl});
            exp_wr.push_back(wr_t'{BASE, k + 1});
        end else begin
            p.f = 1;
        end
        exp_pk.push_back(p);
        n_exp++;
    endtask

    // Called at a negedge; returns at the negedge after the handshake completes
    task automatic send(int src, int bat, int val, int cl);
        int n;
        bus.fsourceID    = 16'(src);
        bus.fbatteryStat = 16'(bat);
        bus.fValue       = 16'(val);
        bus.fclusterID   = 16'(cl);
        bus.in_valid     = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) fail_now("send_timeout");
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic push(int src, int bat, int val, int cl);
        apply(src, bat, val, cl);
        send(src, bat, val, cl);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_pk.size() != 0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 5000) fail_now("drain_timeout");
        repeat (2) @(negedge clock);
    endtask

    task automatic pre_write(int a, int d);
        @(negedge clock);
        pre_addr = 9'(a);
        pre_data = 16'(d);
        pre_we   = 1'b1;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    task automatic clear_table();
        m_id.delete();
        m_q.delete();
        m_cl.delete();
        pre_write(BASE, 0);
    endtask

    task automatic set_entry(int id, int q, int cl);
        int k;
        k = m_id.size();
        m_id.push_back(id);
        m_q.push_back(q);
        m_cl.push_back(cl);
        pre_write(ent(k), id);
        pre_write(ent(k) + 2, q);
        pre_write(ent(k) + 4, cl);
        pre_write(BASE, k + 1);
    endtask

    always @(negedge clock) begin
        if (nreset && mon_en) begin
            if (bus.wr_en) begin
                if (exp_wr.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr", int'(bus.address), mon_e.addr);
                    chk("wr_data", int'(bus.data_in), mon_e.data);
                end
            end
            if (bus.reinit)       r_cnt++;
            if (bus.tbl_full_err) f_cnt++;
            if (bus.done) begin
                n_done++;
                if (exp_pk.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    mon_p = exp_pk.pop_front();
                    chk("reinit_pulses", r_cnt, mon_p.r);
                    chk("full_err_pulses", f_cnt, mon_p.f);
                end
                r_cnt = 0;
                f_cnt = 0;
            end
        end
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.fsourceID = '0;
        bus.fbatteryStat = '0;
        bus.fValue = '0;
        bus.fclusterID = '0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_address", int'(bus.address), 0);
        chk("rst_done", int'(bus.done), 0);
        nreset = 1'b1;

        // Empty-table append, learning step, cluster change
        clear_table();
        push(1, 5, 10, 11);
        drain();
        chk("t1_cnt", int'(mem['h100]), 1);
        chk("t1_q", int'(mem['h104]), 15);
        push(1, 5, 30, 11);
        drain();
        chk("t2_q", int'(mem['h104]), 20);
        push(1, 5, 30, 12);
        drain();
        chk("t4_cl", int'(mem['h106]), 12);

        // Negative step floors toward -inf
        clear_table();
        set_entry(1, 40, 11);
        push(1, 3, 5, 11);
        drain();
        chk("t3_q_down", int'(mem['h104]), 32);
        push(1, 20, 19, 11);
        drain();
        chk("t3_q_up", int'(mem['h104]), 33);

        // Full table: drop unknown, hit last entry, saturate target
        clear_table();
        for (int i = 0; i < NMAX; i++) set_entry(i + 1, 100, 1);
        push(9, 1, 1, 1);
        push(8, 0, 60, 1);
        push(2, 'hFFFF, 'h10, 1);
        drain();
        chk("full_cnt", int'(mem[BASE]), 8);
        chk("last_entry_q", int'(mem[ent(7) + 2]), 90);
        chk("sat_q", int'(mem[ent(1) + 2]), 16458);

        // Back-to-back burst into an idle block fills the queue
        clear_table();
        for (int i = 1; i <= 5; i++) push(i, $urandom_range(0, 300), $urandom_range(0, 1000), 1);
        chk("backpressure_ready", int'(bus.in_ready), 0);
        drain();

        for (int i = 0; i < 150; i++) begin
            int s, b, v, c;
            s = $urandom_range(1, 12);
            b = $urandom_range(0, 300);
            v = ($urandom_range(0, 7) == 0) ? $urandom_range('hFF00, 'hFFFF) : $urandom_range(0, 1000);
            c = $urandom_range(1, 3);
            push(s, b, v, c);
        end
        drain();
        chk("done_count", n_done, n_exp);
        chk("exp_wr_left", exp_wr.size(), 0);

        // Reset while the Q write is strobed: the write must not land
        mon_en = 1'b0;
        send(m_id[0], 1000, 1000, m_cl[0]);
        n = 0;
        while (!bus.wr_en && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) fail_now("wrq_timeout");
        chk("wrq_addr", int'(bus.address), ent(0) + 2);
        nreset = 1'b0;
        #1;
        chk("abort_wr_en", int'(bus.wr_en), 0);
        chk("abort_address", int'(bus.address), 0);
        chk("abort_data_in", int'(bus.data_in), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        @(posedge clock);
        #1;
        chk("abort_no_write", int'(mem[ent(0) + 2]), m_q[0]);
        @(negedge clock);
        nreset = 1'b1;

        chk("tbl_cnt", int'(mem[BASE]), m_id.size());
        for (int i = 0; i < m_id.size(); i++) begin
            chk("tbl_id", int'(mem[ent(i)]), m_id[i]);
            chk("tbl_q", int'(mem[ent(i) + 2]), m_q[i]);
            chk("tbl_cl", int'(mem[ent(i) + 4]), m_cl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
